mem_arbiter: RTL

Two-port arbiter that shares the single-port 16-bit data memory (MEM, 4096 words, asynchronous read, synchronous write) between the processor's memory port (port 0) and a second requester such as a DMA or debug loader (port 1). Each access uses a request/acknowledge handshake. Requesters are served round-robin, and a per-port LOCK holds ownership for atomic read-modify-write sequences. Addresses outside the memory window are acknowledged without touching MEM and return a fixed filler value.

---
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the two-port memory arbiter.
// Index 0 is the processor port, index 1 the secondary requester.
interface mem_arbiter_if #(
    parameter int DBITS = 16
);
    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            lock;
    logic [1:0][15:0]      addr;
    logic [1:0][DBITS-1:0] wdata;
    logic [1:0]            ack;
    logic [DBITS-1:0]      rdata;
    logic                  busy;
    logic                  owner;

    modport master (
        output req, we, lock, addr, wdata,
        input  ack, rdata, busy, owner
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output ack, rdata, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters,
// with per-port lock for atomic sequences and a filler value for unmapped addresses.
module mem_arbiter #(
    parameter int               DBITS     = 16,
    parameter int               ABITS     = 12,
    parameter logic [DBITS-1:0] NOMEM_VAL = 16'hDEAD
) (
    input  logic              clk,
    input  logic              resetn,
    mem_arbiter_if.slave      bus,
    output logic [ABITS-1:0]  maddr,
    output logic [DBITS-1:0]  mdin,
    output logic              mwe,
    input  logic [DBITS-1:0]  mdout
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic             pri;
    logic             locked;
    logic             owner;
    logic             busy;
    logic [1:0]       ack;
    logic [DBITS-1:0] rdata;
    logic             in_range;
    logic             grant;

    assign bus.ack   = ack;
    assign bus.rdata = rdata;
    assign bus.busy  = busy;
    assign bus.owner = owner;

    assign in_range = (bus.addr[owner][15:ABITS+1] == '0);

    // Contention goes to the locked owner if it holds a lock, else to the pointer.
    always_comb begin
        grant = bus.req[1];
        if (bus.req == 2'b11)
            grant = locked ? owner : pri;
    end

    // Memory strobes are live only in ACCESS; resetn gating kills an interrupted write.
    always_comb begin
        maddr = '0;
        mdin  = '0;
        mwe   = 1'b0;
        if (state == ACCESS) begin
            maddr = bus.addr[owner][ABITS:1];
            mdin  = bus.wdata[owner];
            mwe   = bus.we[owner] & in_range & resetn;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            pri    <= 1'b0;
            locked <= 1'b0;
            owner  <= 1'b0;
            busy   <= 1'b0;
            ack    <= 2'b00;
            rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner <= grant;
                        busy  <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata <= in_range ? mdout : NOMEM_VAL;
                    ack   <= owner ? 2'b10 : 2'b01;
                    state <= DONE;
                end
                DONE: begin
                    ack    <= 2'b00;
                    busy   <= 1'b0;
                    pri    <= ~owner;
                    locked <= bus.lock[owner];
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
